ps2_cmd_ctrl: RTL

Command sequencer for one PS/2 port. It drives the port's transmitter (`tbr`/`data`/`sent`/`tx_en`) and receiver (`rx_en`/`rx_rdy`/`rx_data`) to run complete host-to-device command transactions: send the byte, collect the 0xFA ACK, resend on 0xFE, enforce timeouts, and handle the 0xFF reset response (0xAA, then the ID byte). It sits between the keyboard/mouse peripheral controller and the port's tx/rx pair. Received bytes outside a transaction pass through as stream data.

---
 rtl/ps2_cmd_ctrl_if.sv | 32 +++
 rtl/ps2_cmd_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_ctrl_if.sv
// Handshake bundle between the PS/2 command sequencer, its host and the port tx/rx pair.
// slave = sequencer view, master = host plus tx/rx side.
interface ps2_cmd_ctrl_if;
    logic       cmd_req;
    logic [7:0] cmd_byte;
    logic       cmd_busy;
    logic       cmd_done;
    logic       cmd_err;
    logic [7:0] resp_byte;
    logic       tx_en;
    logic       tbr;
    logic [7:0] tx_data;
    logic       sent;
    logic       rx_en;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       stream_valid;
    logic [7:0] stream_data;
    logic       init_done;

    modport slave (
        input  cmd_req, cmd_byte, sent, rx_rdy, rx_data,
        output cmd_busy, cmd_done, cmd_err, resp_byte, tx_en, tbr, tx_data,
               rx_en, stream_valid, stream_data, init_done
    );

    modport master (
        output cmd_req, cmd_byte, sent, rx_rdy, rx_data,
        input  cmd_busy, cmd_done, cmd_err, resp_byte, tx_en, tbr, tx_data,
               rx_en, stream_valid, stream_data, init_done
    );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command sequencer: send, ACK/resend, timeouts, 0xFF reset response, stream pass-through.
// Optional power-on init (0xFF then 0xF4) when PS2_CMD_INIT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT      | power-on sequencer picks next init command (PS2_CMD_INIT_EN)
// IDLE      | receiver on, forwarding stream bytes, accepting cmd_req
// LOAD      | tbr strobe, byte handed to transmitter
// WAIT_SENT | transmitter shifting the frame out
// WAIT_ACK  | waiting for 0xFA / 0xFE / error byte
// WAIT_BAT  | after 0xFF ACK, waiting for 0xAA self-test pass
// WAIT_ID   | waiting for the device ID byte (absent on keyboards)
// DONE      | one-cycle completion, cmd_done pulse
module ps2_cmd_ctrl #(
    parameter logic [25:0] ACK_TIMEOUT = 26'd2_000_000,
    parameter logic [25:0] BAT_TIMEOUT = 26'd50_000_000,
    parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
    input  logic           clk,
    input  logic           rst,
    ps2_cmd_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_SENT,
        WAIT_ACK,
        WAIT_BAT,
        WAIT_ID,
        DONE
`ifdef PS2_CMD_INIT_EN
        , INIT
`endif
    } state_t;

    localparam logic [7:0] B_ACK    = 8'hFA;
    localparam logic [7:0] B_RESEND = 8'hFE;
    localparam logic [7:0] B_RESET  = 8'hFF;
    localparam logic [7:0] B_BAT_OK = 8'hAA;

    state_t      state;
    logic [7:0]  cmd_lat;
    logic [1:0]  retry_cnt;
    logic [25:0] timer;
    logic        timer_exp;

    logic        resend;
    logic        retry_go;
    logic        fin;
    logic        fin_err;
    logic [7:0]  fin_resp;
    logic        load_go;
    logic [7:0]  load_byte;

`ifdef PS2_CMD_INIT_EN
    logic        in_init;
    logic        init_phase;
    logic        init_done_r;

    assign bus.init_done = init_done_r;
`else
    assign bus.init_done = 1'b1;
`endif

    assign timer_exp = (timer == 26'd0);

    // Per-state decision: a received byte always outranks timer expiry,
    // and sent outranks expiry while the frame is going out.
    always_comb begin
        resend   = 1'b0;
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_resp = bus.resp_byte;
        case (state)
            LOAD:      resend = timer_exp;
            WAIT_SENT: resend = !bus.sent && timer_exp;
            WAIT_ACK: begin
                if (bus.rx_rdy) begin
                    fin_resp = bus.rx_data;
                    if (bus.rx_data == B_ACK) begin
                        fin = (cmd_lat != B_RESET);
                    end else if (bus.rx_data == B_RESEND) begin
                        resend = 1'b1;
                    end else begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                end else begin
                    resend = timer_exp;
                end
            end
            WAIT_BAT: begin
                if (bus.rx_rdy) begin
                    fin_resp = bus.rx_data;
                    if (bus.rx_data != B_BAT_OK) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                end else if (timer_exp) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            WAIT_ID: begin
                if (bus.rx_rdy) begin
                    fin      = 1'b1;
                    fin_resp = bus.rx_data;
                end else if (timer_exp) begin
                    // keyboards never send an ID after the self-test byte
                    fin      = 1'b1;
                    fin_resp = B_BAT_OK;
                end
            end
            default: ;
        endcase

        retry_go = resend && (retry_cnt < MAX_RETRY);
        if (resend && !retry_go) begin
            fin     = 1'b1;
            fin_err = 1'b1;
        end

        load_go   = (state == IDLE && bus.cmd_req) || retry_go;
        load_byte = (state == IDLE) ? bus.cmd_byte : cmd_lat;
`ifdef PS2_CMD_INIT_EN
        if (state == INIT) begin
            load_go   = 1'b1;
            load_byte = init_phase ? 8'hF4 : B_RESET;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
`ifdef PS2_CMD_INIT_EN
            state        <= INIT;
            bus.cmd_busy <= 1'b1;
            in_init      <= 1'b1;
            init_phase   <= 1'b0;
            init_done_r  <= 1'b0;
`else
            state        <= IDLE;
            bus.cmd_busy <= 1'b0;
`endif
            cmd_lat          <= 8'h00;
            retry_cnt        <= 2'd0;
            timer            <= 26'd0;
            bus.tx_en        <= 1'b0;
            bus.tbr          <= 1'b0;
            bus.tx_data      <= 8'h00;
            bus.rx_en        <= 1'b0;
            bus.cmd_done     <= 1'b0;
            bus.cmd_err      <= 1'b0;
            bus.resp_byte    <= 8'h00;
            bus.stream_valid <= 1'b0;
            bus.stream_data  <= 8'h00;
        end else begin
            bus.tbr          <= 1'b0;
            bus.cmd_done     <= 1'b0;
            bus.stream_valid <= 1'b0;

            if (!timer_exp) begin
                timer <= timer - 26'd1;
            end

            if (state == IDLE && bus.rx_rdy) begin
                bus.stream_valid <= 1'b1;
                bus.stream_data  <= bus.rx_data;
            end

            if (load_go) begin
                state        <= LOAD;
                bus.tbr      <= 1'b1;
                bus.tx_en    <= 1'b1;
                bus.rx_en    <= 1'b0;
                bus.tx_data  <= load_byte;
                bus.cmd_busy <= 1'b1;
                timer        <= ACK_TIMEOUT;
                if (retry_go) begin
                    retry_cnt <= retry_cnt + 2'd1;
                end else begin
                    retry_cnt <= 2'd0;
                    cmd_lat   <= load_byte;
                end
                // a latched init error is cleared by the first host command
                if (state == IDLE) begin
                    bus.cmd_err <= 1'b0;
                end
            end else if (fin) begin
                state         <= DONE;
                bus.tx_en     <= 1'b0;
                bus.rx_en     <= 1'b1;
                bus.cmd_err   <= fin_err;
                bus.resp_byte <= fin_resp;
`ifdef PS2_CMD_INIT_EN
                bus.cmd_done  <= !in_init;
`else
                bus.cmd_done  <= 1'b1;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        bus.rx_en    <= 1'b1;
                        bus.tx_en    <= 1'b0;
                        bus.cmd_busy <= 1'b0;
                    end
                    LOAD: state <= WAIT_SENT;
                    WAIT_SENT: begin
                        if (bus.sent) begin
                            state     <= WAIT_ACK;
                            bus.tx_en <= 1'b0;
                            bus.rx_en <= 1'b1;
                        end
                    end
                    WAIT_ACK: begin
                        // only the 0xFF ACK reaches here; every other byte was resolved above
                        if (bus.rx_rdy) begin
                            state <= WAIT_BAT;
                            timer <= BAT_TIMEOUT;
                        end
                    end
                    WAIT_BAT: begin
                        if (bus.rx_rdy) begin
                            state <= WAIT_ID;
                            timer <= ACK_TIMEOUT;
                        end
                    end
                    DONE: begin
`ifdef PS2_CMD_INIT_EN
                        if (in_init && !bus.cmd_err && !init_phase) begin
                            init_phase <= 1'b1;
                            state      <= INIT;
                        end else begin
                            if (in_init) begin
                                init_done_r <= 1'b1;
                            end
                            in_init      <= 1'b0;
                            state        <= IDLE;
                            bus.cmd_busy <= 1'b0;
                        end
`else
                        state        <= IDLE;
                        bus.cmd_busy <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
